// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: bubble encoding, reset PC, PC step,
// fetch FSM state encoding and the {instr,pc} entry carried through the skid.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] IFU_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IFU_IDLE    = 2'd0,
    IFU_BUSY    = 2'd1,
    IFU_DISCARD = 2'd2
  } ifu_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit (master)
// and the instruction memory (slave).
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry fetch skid buffer holding an {instr,pc} pair while IF/ID stalls.
module instruction_fetch_unit_skid
  import instruction_fetch_unit_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t dout_o,
  output logic         full_o
);

  fetch_entry_t data_q;
  logic         full_q;

  always_ff @(posedge clock) begin
    if (reset || flush_i) full_q <= 1'b0;
    else if (push_i)      full_q <= 1'b1;
    else if (pop_i)       full_q <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset)       data_q <= '0;
    else if (push_i) data_q <= din_i;
  end

  assign dout_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, imem request FSM, IF/ID output registers and skid buffer.
// Build option IFU_MISALIGN_CHECK_EN: misaligned redirects halt fetch and pulse fetch_misaligned.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            redirect,
  input  logic [31:0]                     redirect_pc,
  instruction_fetch_unit_if.master        imem,
  output logic [31:0]                     if_instruction,
  output logic [31:0]                     if_pc,
  output logic                            if_valid,
  output logic                            fetch_misaligned
);

  ifu_state_t   state_q, state_d;
  logic [31:0]  pc_q, pc_d, req_addr_q;
  logic         out_valid_q;
  logic [31:0]  out_instr_q, out_pc_q;
  logic         keep, skid_push, skid_pop, skid_full, skid_full_after;
  logic         can_issue, issue, halt, bad_redirect;
  logic [31:0]  target;
  fetch_entry_t xfer_entry, skid_entry;

  assign target = redirect_pc & WORD_MASK;

`ifdef IFU_MISALIGN_CHECK_EN
  logic halt_q, misalign_q;
  assign bad_redirect = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (reset) begin
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= bad_redirect;
      if (redirect) halt_q <= bad_redirect;
    end
  end

  assign halt             = halt_q;
  assign fetch_misaligned = misalign_q;
`else
  assign bad_redirect     = 1'b0;
  assign halt             = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  // A transfer is only kept when it is for a live (non-discarded) request.
  assign keep       = (state_q == IFU_BUSY) && imem.imem_ready && !redirect;
  assign skid_push  = stall && keep && out_valid_q && !redirect;
  assign skid_pop   = !stall && skid_full && !redirect;
  assign skid_full_after = redirect  ? 1'b0 :
                           skid_push ? 1'b1 :
                           skid_pop  ? 1'b0 : skid_full;
  assign can_issue  = !redirect && !skid_full_after && !halt;

  assign xfer_entry.instr = imem.imem_rdata;
  assign xfer_entry.pc    = req_addr_q;

  instruction_fetch_unit_skid u_skid (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .din_i   (xfer_entry),
    .dout_o  (skid_entry),
    .full_o  (skid_full)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IFU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE:    if (can_issue) state_d = IFU_BUSY;
      IFU_BUSY: begin
        if (redirect)                state_d = imem.imem_ready ? IFU_IDLE : IFU_DISCARD;
        else if (imem.imem_ready)    state_d = can_issue ? IFU_BUSY : IFU_IDLE;
      end
      IFU_DISCARD: if (imem.imem_ready) state_d = IFU_IDLE;
      default:     state_d = IFU_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = (state_q != IFU_IDLE);
    issue = 1'b0;
    if (can_issue && ((state_q == IFU_IDLE) || (state_q == IFU_BUSY && imem.imem_ready)))
      issue = 1'b1;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      if (!bad_redirect) pc_d = target;
    end else if (issue) begin
      pc_d = next_pc(pc_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      req_addr_q  <= 32'h0;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (issue) req_addr_q <= pc_q;
      if (redirect) begin
        out_valid_q <= 1'b0;
      end else if (!stall) begin
        if (skid_full) begin
          out_valid_q <= 1'b1;
          out_instr_q <= skid_entry.instr;
          out_pc_q    <= skid_entry.pc;
        end else if (keep) begin
          out_valid_q <= 1'b1;
          out_instr_q <= xfer_entry.instr;
          out_pc_q    <= xfer_entry.pc;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (keep && !out_valid_q) begin
        out_valid_q <= 1'b1;
        out_instr_q <= xfer_entry.instr;
        out_pc_q    <= xfer_entry.pc;
      end
    end
  end

  assign imem.imem_addr = req_addr_q;
  assign if_valid       = out_valid_q;
  assign if_instruction = out_valid_q ? out_instr_q : NOP_INSTR;
  assign if_pc          = out_valid_q ? out_pc_q : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run scored against an in-order fetch-stream reference model.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] if_instruction, if_pc;
  logic        if_valid, fetch_misaligned;

  int          checks = 0;
  int          failures = 0;
  int          shown = 0;
  logic [31:0] exp_pc = 32'h0;
  bit          halted = 1'b0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .imem             (bus),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_valid         (if_valid),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb bus.imem_rdata = memf(bus.imem_addr);

  // One clock: apply inputs at a falling edge, let the rising edge act, then
  // score the new outputs against the expected in-order stream at the next falling edge.
  task automatic tick(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
    logic        pv, preq;
    logic [31:0] ppc, pins, paddr;
    pv = if_valid; ppc = if_pc; pins = if_instruction;
    preq = bus.imem_req; paddr = bus.imem_addr;
    stall = s; redirect = r; redirect_pc = rpc; bus.imem_ready = rdy;
    @(negedge clock);
    redirect = 1'b0;
    if (r) begin
      checks++;
      if (if_valid !== 1'b0) begin
        failures++; $display("FAIL redirect_flush if_valid=%b want 0", if_valid);
      end
`ifdef IFU_MISALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) halted = 1'b1;
      else begin halted = 1'b0; exp_pc = rpc; end
`else
      exp_pc = rpc & 32'hFFFF_FFFC;
`endif
    end else if (pv && s) begin
      checks++;
      if (if_valid !== 1'b1 || if_pc !== ppc || if_instruction !== pins) begin
        failures++;
        $display("FAIL stall_hold valid=%b pc=%h instr=%h want 1 %h %h", if_valid, if_pc, if_instruction, ppc, pins);
      end
    end else if (if_valid === 1'b1) begin
      checks++;
      if (halted || if_pc !== exp_pc || if_instruction !== memf(exp_pc)) begin
        failures++;
        $display("FAIL fetch_order pc=%h instr=%h want %h %h halted=%0d", if_pc, if_instruction, exp_pc, memf(exp_pc), halted);
      end
      exp_pc = exp_pc + 32'd4;
      shown++;
    end
    if (if_valid !== 1'b1) begin
      checks++;
      if (if_instruction !== 32'h0000_0013 || if_pc !== 32'h0) begin
        failures++; $display("FAIL bubble instr=%h pc=%h want 00000013 0", if_instruction, if_pc);
      end
    end
    if (preq && !rdy) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== paddr) begin
        failures++; $display("FAIL addr_stable req=%b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, paddr);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; bus.imem_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || if_valid !== 1'b0 ||
        if_instruction !== 32'h0000_0013 || if_pc !== 32'h0 || fetch_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_values req=%b addr=%h valid=%b instr=%h pc=%h mis=%b want 0 0 0 00000013 0 0",
               bus.imem_req, bus.imem_addr, if_valid, if_instruction, if_pc, fetch_misaligned);
    end
    reset = 1'b0; exp_pc = 32'h0; halted = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL first_req req=%b addr=%h valid=%b want 1 0 0", bus.imem_req, bus.imem_addr, if_valid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (bus.imem_addr !== 32'(4 * k) || if_pc !== 32'(4 * (k - 1)) || if_valid !== 1'b1) begin
        failures++;
        $display("FAIL stream k=%0d addr=%h pc=%h valid=%b want %h %h 1", k, bus.imem_addr, if_pc, if_valid, 32'(4 * k), 32'(4 * (k - 1)));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    do_reset();
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b1);
    held = if_pc;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (if_pc !== held || if_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
        failures++; $display("FAIL stall_freeze i=%0d pc=%h valid=%b req=%b want %h 1 0", i, if_pc, if_valid, bus.imem_req, held);
      end
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_pc !== held + 32'd4 || bus.imem_req !== 1'b1 || bus.imem_addr !== held + 32'd8) begin
      failures++; $display("FAIL stall_release pc=%h req=%b addr=%h want %h 1 %h", if_pc, bus.imem_req, bus.imem_addr, held + 32'd4, held + 32'd8);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_pc !== held + 32'd8) begin
      failures++; $display("FAIL stall_resume pc=%h want %h", if_pc, held + 32'd8);
    end
  endtask

  task automatic test_wait();
    do_reset();
    repeat (4) tick(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || if_valid !== 1'b0) begin
        failures++; $display("FAIL wait_hold i=%0d req=%b addr=%h valid=%b want 1 10 0", i, bus.imem_req, bus.imem_addr, if_valid);
      end
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10) begin
      failures++; $display("FAIL wait_data valid=%b pc=%h want 1 10", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (8) tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h100, 1'b0);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin
      failures++; $display("FAIL redirect_pending req=%b addr=%h want 1 20", bus.imem_req, bus.imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL redirect_drop valid=%b req=%b want 0 0", if_valid, bus.imem_req);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      failures++; $display("FAIL redirect_target req=%b addr=%h want 1 100", bus.imem_req, bus.imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
      failures++; $display("FAIL redirect_show valid=%b pc=%h want 1 100", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 32'h200, 1'b1);
    checks++;
    if (if_valid !== 1'b0 || if_instruction !== 32'h0000_0013) begin
      failures++; $display("FAIL redirect_stall valid=%b instr=%h want 0 00000013", if_valid, if_instruction);
    end
    repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      failures++; $display("FAIL redirect_stall_resume valid=%b pc=%h want 1 200", if_valid, if_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin
      failures++; $display("FAIL pc_wrap pc=%h addr=%h want fffffffc 0", if_pc, bus.imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_misalign();
    do_reset();
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h102, 1'b1);
`ifdef IFU_MISALIGN_CHECK_EN
    checks++;
    if (fetch_misaligned !== 1'b1) begin
      failures++; $display("FAIL misalign_pulse got %b want 1", fetch_misaligned);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (fetch_misaligned !== 1'b0) begin
      failures++; $display("FAIL misalign_once got %b want 0", fetch_misaligned);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (bus.imem_req !== 1'b0 || if_valid !== 1'b0) begin
        failures++; $display("FAIL misalign_halt i=%0d req=%b valid=%b want 0 0", i, bus.imem_req, if_valid);
      end
    end
    tick(1'b0, 1'b1, 32'h300, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin
      failures++; $display("FAIL misalign_recover req=%b addr=%h want 1 300", bus.imem_req, bus.imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
`else
    checks++;
    if (fetch_misaligned !== 1'b0) begin
      failures++; $display("FAIL misalign_tied got %b want 0", fetch_misaligned);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      failures++; $display("FAIL misalign_forced req=%b addr=%h want 1 100", bus.imem_req, bus.imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== memf(32'h0)) begin
      failures++; $display("FAIL reset_mid valid=%b pc=%h instr=%h want 1 0 %h", if_valid, if_pc, if_instruction, memf(32'h0));
    end
  endtask

  task automatic test_random();
    logic s, r, rdy;
    logic [31:0] rpc;
    do_reset();
    shown = 0;
    for (int i = 0; i < 600; i++) begin
      s   = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 65);
      r   = ($urandom_range(0, 99) < 4);
      rpc = 32'($urandom_range(0, 1023)) << 2;
      tick(s, r, rpc, rdy);
    end
    checks++;
    if (shown < 50) begin
      failures++; $display("FAIL random_progress shown=%0d want >=50", shown);
    end
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_stream();
    test_stall();
    test_wait();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
